decode_stage_p: RTL and testbench

Parametrised next-generation decode stage for the Beta 5-stage pipeline. Holds the decode instruction register (IR) and PC, and reads operands from the register file with N-stage priority bypass. Generates the load-use interlock, resolves BEQ/BNE/JMP in decode with a one-shot fetch annul, and injects exception instructions for illegal opcodes and interrupts. Sits between fetch and execute.

---
 rtl/beta_pkg.sv | 52 +++++
 rtl/decode_stage_p_if.sv | 45 ++++
 rtl/beta_regfile.sv | 38 +++
 rtl/decode_stage_p.sv | 170 +++++++++++++++++
 tb/tb_decode_stage_p.sv | 386 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/beta_pkg.sv
// Shared Beta ISA definitions for the decode stage: opcodes, fixed
// instruction encodings, architectural register indices and the
// opcode-class enum used by the decoder.
package beta_pkg;

    localparam logic [5:0] OPC_LD  = 6'h18;
    localparam logic [5:0] OPC_ST  = 6'h19;
    localparam logic [5:0] OPC_JMP = 6'h1B;
    localparam logic [5:0] OPC_BEQ = 6'h1C;
    localparam logic [5:0] OPC_BNE = 6'h1D;
    localparam logic [5:0] OPC_LDR = 6'h1F;
    localparam logic [5:0] OPC_ADD = 6'h20;

    localparam logic [4:0] R31 = 5'd31;
    localparam logic [4:0] XP  = 5'd30;

    // ADD(R31,R31,R31): the pipeline bubble.
    localparam logic [31:0] NOP    = {OPC_ADD, R31, R31, R31, 11'd0};
    // BNE(R31,0,XP): saves the PC+4 of the faulting instruction in XP.
    localparam logic [31:0] BNE_XP = {OPC_BNE, XP, R31, 16'h0000};

    typedef enum logic [2:0] {
        CLS_LD,
        CLS_ST,
        CLS_LDR,
        CLS_JMP,
        CLS_BR,
        CLS_OP,
        CLS_OPC,
        CLS_ILL
    } op_class_t;

    // Map a 6-bit opcode onto its decode class; 10xxxx are register ALU
    // ops, 11xxxx are literal ALU ops, everything unlisted is illegal.
    function automatic op_class_t classify(input logic [5:0] opc);
        op_class_t c;
        case (opc)
            OPC_LD:           c = CLS_LD;
            OPC_ST:           c = CLS_ST;
            OPC_LDR:          c = CLS_LDR;
            OPC_JMP:          c = CLS_JMP;
            OPC_BEQ, OPC_BNE: c = CLS_BR;
            default: begin
                if (opc[5:4] == 2'b10)      c = CLS_OP;
                else if (opc[5:4] == 2'b11) c = CLS_OPC;
                else                        c = CLS_ILL;
            end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/decode_stage_p_if.sv
// Bundle of every non-clock signal between fetch, the bypass network,
// writeback and the decode stage. The decode stage uses the slave view.
// Handshake: there is no valid/ready pair; stall_out is a level "hold"
// back to fetch, stall_in a level freeze from downstream, and
// redirect_valid a single-cycle qualifier for redirect_pc.
interface decode_stage_p_if #(
    parameter int DATA_W  = 32,
    parameter int NUM_BYP = 3
);
    logic [31:0]             inst_in;
    logic [DATA_W-1:0]       pc_plus_four_in;
    logic                    stall_in;
    logic                    irq_in;
    logic [NUM_BYP*5-1:0]    byp_rc;
    logic [NUM_BYP-1:0]      byp_we;
    logic [NUM_BYP-1:0]      byp_ready;
    logic [NUM_BYP*DATA_W-1:0] byp_data;
    logic                    rf_we;
    logic [4:0]              rf_wa;
    logic [DATA_W-1:0]       rf_wd;
    logic [31:0]             inst_next;
    logic [DATA_W-1:0]       pc_next;
    logic [DATA_W-1:0]       a_data;
    logic [DATA_W-1:0]       b_data;
    logic [DATA_W-1:0]       st_data;
    logic                    stall_out;
    logic                    redirect_valid;
    logic [DATA_W-1:0]       redirect_pc;

    modport master (
        output inst_in, pc_plus_four_in, stall_in, irq_in,
        output byp_rc, byp_we, byp_ready, byp_data,
        output rf_we, rf_wa, rf_wd,
        input  inst_next, pc_next, a_data, b_data, st_data,
        input  stall_out, redirect_valid, redirect_pc
    );

    modport slave (
        input  inst_in, pc_plus_four_in, stall_in, irq_in,
        input  byp_rc, byp_we, byp_ready, byp_data,
        input  rf_we, rf_wa, rf_wd,
        output inst_next, pc_next, a_data, b_data, st_data,
        output stall_out, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/beta_regfile.sv
// 31-entry Beta register file: two combinational read ports, one write
// port. A write in the same cycle is forwarded to the readers and R31
// always reads as zero.
module beta_regfile
    import beta_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic [4:0]        ra1,
    input  logic [4:0]        ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic              we,
    input  logic [4:0]        wa,
    input  logic [DATA_W-1:0] wd
);

    logic [DATA_W-1:0] mem [0:31];

    // Writeback; R31 is never stored.
    always_ff @(posedge clk) begin
        if (we && wa != R31) mem[wa] <= wd;
    end

    // Port 1 read with write-through.
    always_comb begin
        rd1 = '0;
        if (ra1 != R31) rd1 = (we && wa == ra1) ? wd : mem[ra1];
    end

    // Port 2 read with write-through.
    always_comb begin
        rd2 = '0;
        if (ra2 != R31) rd2 = (we && wa == ra2) ? wd : mem[ra2];
    end

endmodule

// File: rtl/decode_stage_p.sv
// Beta decode stage: IR/PC register, operand read with priority bypass,
// load-use interlock, decode-time branch/JMP resolution with a one-shot
// fetch annul, and exception injection for illegal opcodes.
// Optional interrupt injection is compiled in with `define DECODE_IRQ_EN.
module decode_stage_p
    import beta_pkg::*;
#(
    parameter int                DATA_W      = 32,
    parameter int                NUM_BYP     = 3,
    parameter logic [DATA_W-1:0] RESET_PC    = '0,
    parameter logic [DATA_W-1:0] XADDR_ILLOP = 'h4,
    parameter logic [DATA_W-1:0] XADDR_IRQ   = 'h8
) (
    input logic             clk,
    input logic             rst_n,
    decode_stage_p_if.slave bus
);

    logic [31:0]       ir_dec;
    logic [DATA_W-1:0] pc_dec;
    logic              annul;
    logic              irq_pend;

    logic [5:0]        opc;
    logic [4:0]        rc, ra, rb;
    logic [15:0]       lit;
    op_class_t         cls;
    logic [4:0]        ra1, ra2;
    logic [DATA_W-1:0] rf_rd1, rf_rd2;
    logic [DATA_W-1:0] sxt, br_target;

    logic [DATA_W-1:0] op1, op2;
    logic              hit1, hit2, hazard;
    logic              stall, ill, irq_take, taken;

    logic [31:0]       inst_next_c;
    logic [DATA_W-1:0] a_c, b_c;
    logic              rv_c;
    logic [DATA_W-1:0] rpc_c;

    assign opc = ir_dec[31:26];
    assign rc  = ir_dec[25:21];
    assign ra  = ir_dec[20:16];
    assign rb  = ir_dec[15:11];
    assign lit = ir_dec[15:0];
    assign cls = classify(opc);

    // ST reads its store data from Rc through the second port.
    assign ra1 = ra;
    assign ra2 = (cls == CLS_ST) ? rc : rb;

    assign sxt       = {{(DATA_W-16){lit[15]}}, lit};
    assign br_target = pc_dec + {sxt[DATA_W-3:0], 2'b00};

    beta_regfile #(.DATA_W(DATA_W)) u_regfile (
        .clk (clk),
        .ra1 (ra1),
        .ra2 (ra2),
        .rd1 (rf_rd1),
        .rd2 (rf_rd2),
        .we  (bus.rf_we),
        .wa  (bus.rf_wa),
        .wd  (bus.rf_wd)
    );

    // Bypass: first matching stage (lowest index) wins; a match whose data
    // is not ready yet is a load-use hazard.
    always_comb begin
        op1    = rf_rd1;
        op2    = rf_rd2;
        hit1   = 1'b0;
        hit2   = 1'b0;
        hazard = 1'b0;
        for (int i = 0; i < NUM_BYP; i++) begin
            if (!hit1 && bus.byp_we[i] && ra1 != R31 && bus.byp_rc[i*5 +: 5] == ra1) begin
                hit1 = 1'b1;
                op1  = bus.byp_data[i*DATA_W +: DATA_W];
                if (!bus.byp_ready[i]) hazard = 1'b1;
            end
            if (!hit2 && bus.byp_we[i] && ra2 != R31 && bus.byp_rc[i*5 +: 5] == ra2) begin
                hit2 = 1'b1;
                op2  = bus.byp_data[i*DATA_W +: DATA_W];
                if (!bus.byp_ready[i]) hazard = 1'b1;
            end
        end
    end

    assign stall    = hazard | bus.stall_in;
    assign ill      = (cls == CLS_ILL);
    // Illegal opcode outranks the interrupt; an injected IRQ only ever
    // replaces a real instruction in an unstalled cycle.
    assign irq_take = irq_pend && (ir_dec != NOP) && !stall && !ill;

    // Outputs to execute and the fetch redirect.
    always_comb begin
        inst_next_c = ir_dec;
        a_c         = op1;
        b_c         = op2;
        rv_c        = 1'b0;
        rpc_c       = br_target;
        taken       = 1'b0;

        if (hazard && !bus.stall_in) inst_next_c = NOP;
        else if (ill || irq_take)    inst_next_c = BNE_XP;

        if (ill || irq_take) begin
            a_c = pc_dec;
        end else begin
            case (cls)
                CLS_JMP, CLS_BR: a_c = pc_dec;
                CLS_LDR:         a_c = br_target;
                default:         a_c = op1;
            endcase
        end

        if (cls == CLS_LD || cls == CLS_ST || cls == CLS_OPC) b_c = sxt;

        if (!stall) begin
            if (ill) begin
                rv_c  = 1'b1;
                rpc_c = XADDR_ILLOP;
            end else if (irq_take) begin
                rv_c  = 1'b1;
                rpc_c = XADDR_IRQ;
            end else if (cls == CLS_JMP) begin
                rv_c  = 1'b1;
                rpc_c = {op1[DATA_W-1:2], 2'b00};
            end else if (cls == CLS_BR) begin
                taken = (opc == OPC_BEQ) ? (op1 == '0) : (op1 != '0);
                rv_c  = taken;
            end
        end
    end

    // Decode IR/PC and the annul flag for the instruction fetched behind a redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_dec <= NOP;
            pc_dec <= RESET_PC + DATA_W'(4);
            annul  <= 1'b0;
        end else if (!stall) begin
            ir_dec <= annul ? NOP : bus.inst_in;
            pc_dec <= bus.pc_plus_four_in;
            annul  <= rv_c;
        end
    end

`ifdef DECODE_IRQ_EN
    // Latch the level interrupt; consumed by the cycle that injects it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          irq_pend <= 1'b0;
        else if (bus.irq_in) irq_pend <= 1'b1;
        else if (irq_take)   irq_pend <= 1'b0;
    end
`else
    logic unused_irq;
    assign unused_irq = bus.irq_in;
    assign irq_pend   = 1'b0;
`endif

    assign bus.inst_next      = inst_next_c;
    assign bus.pc_next        = pc_dec;
    assign bus.a_data         = a_c;
    assign bus.b_data         = b_c;
    assign bus.st_data        = op2;
    assign bus.stall_out      = stall;
    assign bus.redirect_valid = rv_c;
    assign bus.redirect_pc    = rpc_c;

endmodule

// File: tb/tb_decode_stage_p.sv
// Directed bench for decode_stage_p: a vector table for single-instruction
// decode behaviour plus hand-written multi-cycle sequences.
module tb_decode_stage_p;

    localparam int DATA_W  = 32;
    localparam int NUM_BYP = 3;

    localparam logic [31:0] T_NOP    = 32'h83FF_F800;
    localparam logic [31:0] T_BNE_XP = 32'h77DF_0000;
    localparam logic [5:0]  T_ADD = 6'h20, T_SUB = 6'h21, T_ADDC = 6'h30;
    localparam logic [5:0]  T_LD  = 6'h18, T_ST  = 6'h19, T_JMP  = 6'h1B;
    localparam logic [5:0]  T_BEQ = 6'h1C, T_BNE = 6'h1D, T_LDR  = 6'h1F;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc4;
        logic        stall_in;
        logic [14:0] byp_rc;
        logic [2:0]  byp_we;
        logic [2:0]  byp_ready;
        logic [95:0] byp_data;
        logic        chk_inst;
        logic        chk_ops;
        logic [31:0] e_inst;
        logic [31:0] e_a;
        logic [31:0] e_b;
        logic [31:0] e_st;
        logic        e_stall;
        logic        e_rv;
        logic [31:0] e_rpc;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    vec_t vecs[20];

    decode_stage_p_if #(.DATA_W(DATA_W), .NUM_BYP(NUM_BYP)) bus ();

    decode_stage_p #(
        .DATA_W      (DATA_W),
        .NUM_BYP     (NUM_BYP),
        .RESET_PC    (32'h0),
        .XADDR_ILLOP (32'h4),
        .XADDR_IRQ   (32'h8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, fails=%0d", fails);
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] rc,
                                        input logic [4:0] ra, input logic [15:0] lit);
        return {op, rc, ra, lit};
    endfunction

    function automatic logic [31:0] rr(input logic [5:0] op, input logic [4:0] rc,
                                       input logic [4:0] ra, input logic [4:0] rb);
        return {op, rc, ra, rb, 11'd0};
    endfunction

    function automatic vec_t mk(
        input logic [31:0] inst, input logic [31:0] pc4, input logic stall_in,
        input logic [14:0] brc, input logic [2:0] bwe, input logic [2:0] brdy,
        input logic [95:0] bdata, input logic chk_inst, input logic chk_ops,
        input logic [31:0] e_inst, input logic [31:0] e_a, input logic [31:0] e_b,
        input logic [31:0] e_st, input logic e_stall, input logic e_rv,
        input logic [31:0] e_rpc);
        vec_t v;
        v.inst = inst; v.pc4 = pc4; v.stall_in = stall_in;
        v.byp_rc = brc; v.byp_we = bwe; v.byp_ready = brdy; v.byp_data = bdata;
        v.chk_inst = chk_inst; v.chk_ops = chk_ops;
        v.e_inst = e_inst; v.e_a = e_a; v.e_b = e_b; v.e_st = e_st;
        v.e_stall = e_stall; v.e_rv = e_rv; v.e_rpc = e_rpc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Driver tasks.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic clear_byp();
        bus.byp_rc    = '0;
        bus.byp_we    = '0;
        bus.byp_ready = '0;
        bus.byp_data  = '0;
    endtask

    task automatic rf_write(input logic [4:0] a, input logic [31:0] d);
        bus.rf_we = 1'b1;
        bus.rf_wa = a;
        bus.rf_wd = d;
        step();
        bus.rf_we = 1'b0;
    endtask

    // Flush any pending annul with two NOP edges, then load one instruction.
    task automatic load_ir(input logic [31:0] inst, input logic [31:0] pc4);
        clear_byp();
        bus.stall_in        = 1'b0;
        bus.irq_in          = 1'b0;
        bus.rf_we           = 1'b0;
        bus.inst_in         = T_NOP;
        bus.pc_plus_four_in = '0;
        step();
        step();
        bus.inst_in         = inst;
        bus.pc_plus_four_in = pc4;
        step();
    endtask

    task automatic run_vec(input int k);
        vec_t v;
        v = vecs[k];
        load_ir(v.inst, v.pc4);
        bus.stall_in  = v.stall_in;
        bus.byp_rc    = v.byp_rc;
        bus.byp_we    = v.byp_we;
        bus.byp_ready = v.byp_ready;
        bus.byp_data  = v.byp_data;
        settle();
        check($sformatf("v%0d stall_out", k), 32'(bus.stall_out), 32'(v.e_stall));
        check($sformatf("v%0d redirect_valid", k), 32'(bus.redirect_valid), 32'(v.e_rv));
        if (v.e_rv) check($sformatf("v%0d redirect_pc", k), bus.redirect_pc, v.e_rpc);
        if (v.chk_inst) check($sformatf("v%0d inst_next", k), bus.inst_next, v.e_inst);
        if (v.chk_ops) begin
            check($sformatf("v%0d a_data", k), bus.a_data, v.e_a);
            check($sformatf("v%0d b_data", k), bus.b_data, v.e_b);
            check($sformatf("v%0d st_data", k), bus.st_data, v.e_st);
        end
    endtask

    initial begin
        logic [31:0] add123, sub546, beq_m2;
        add123 = rr(T_ADD, 5'd1, 5'd2, 5'd3);
        sub546 = rr(T_SUB, 5'd5, 5'd4, 5'd6);
        beq_m2 = enc(T_BEQ, 5'd31, 5'd31, 16'hFFFE);

        vecs[0]  = mk(add123, 32'h104, 0, {5'd2, 5'd0, 5'd2}, 3'b101, 3'b111, {32'd9, 32'd0, 32'd5},
                      1, 1, add123, 32'd5, 32'd7, 32'd7, 0, 0, 0);
        vecs[1]  = mk(add123, 32'h104, 0, {5'd2, 5'd0, 5'd0}, 3'b100, 3'b111, {32'd9, 32'd0, 32'd0},
                      1, 1, add123, 32'd9, 32'd7, 32'd7, 0, 0, 0);
        vecs[2]  = mk(add123, 32'h104, 0, '0, '0, '0, '0,
                      1, 1, add123, 32'h22, 32'd7, 32'd7, 0, 0, 0);
        vecs[3]  = mk(enc(T_ADDC, 5'd1, 5'd2, 16'hFFFD), 32'h104, 0, '0, '0, '0, '0,
                      0, 1, 0, 32'h22, 32'hFFFF_FFFD, 32'd0, 0, 0, 0);
        vecs[4]  = mk(rr(T_ADD, 5'd1, 5'd31, 5'd3), 32'h104, 0, {5'd0, 5'd0, 5'd31}, 3'b001, 3'b001,
                      {64'd0, 32'h55}, 0, 1, 0, 32'd0, 32'd7, 32'd7, 0, 0, 0);
        vecs[5]  = mk(sub546, 32'h104, 0, {5'd0, 5'd0, 5'd4}, 3'b001, 3'b000, '0,
                      1, 0, T_NOP, 0, 0, 0, 1, 0, 0);
        vecs[6]  = mk(enc(T_LD, 5'd4, 5'd2, 16'd8), 32'h104, 0, '0, '0, '0, '0,
                      0, 1, 0, 32'h22, 32'd8, 32'h1000, 0, 0, 0);
        vecs[7]  = mk(enc(T_ST, 5'd6, 5'd2, 16'd12), 32'h104, 0, '0, '0, '0, '0,
                      0, 1, 0, 32'h22, 32'd12, 32'h66, 0, 0, 0);
        vecs[8]  = mk(beq_m2, 32'h100, 0, '0, '0, '0, '0,
                      1, 1, beq_m2, 32'h100, 32'd0, 32'd0, 0, 1, 32'hF8);
        vecs[9]  = mk(enc(T_BNE, 5'd31, 5'd1, 16'd3), 32'h200, 0, '0, '0, '0, '0,
                      0, 1, 0, 32'h200, 32'h1000, 32'h1000, 0, 1, 32'h20C);
        vecs[10] = mk(enc(T_BEQ, 5'd31, 5'd1, 16'd3), 32'h200, 0, '0, '0, '0, '0,
                      0, 1, 0, 32'h200, 32'h1000, 32'h1000, 0, 0, 0);
        vecs[11] = mk(enc(T_BNE, 5'd31, 5'd5, 16'd3), 32'h200, 0, '0, '0, '0, '0,
                      0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[12] = mk(enc(T_JMP, 5'd31, 5'd7, 16'd0), 32'h300, 0, '0, '0, '0, '0,
                      0, 1, 0, 32'h300, 32'h1000, 32'h1000, 0, 1, 32'h1000);
        vecs[13] = mk(32'h0, 32'h40, 0, '0, '0, '0, '0,
                      1, 1, T_BNE_XP, 32'h40, 32'h1000, 32'h1000, 0, 1, 32'h4);
        vecs[14] = mk(enc(T_LDR, 5'd1, 5'd31, 16'd5), 32'h500, 0, '0, '0, '0, '0,
                      0, 1, 0, 32'h514, 32'h1000, 32'h1000, 0, 0, 0);
        vecs[15] = mk(rr(6'h1A, 5'd1, 5'd2, 5'd3), 32'h60, 0, '0, '0, '0, '0,
                      1, 1, T_BNE_XP, 32'h60, 32'd7, 32'd7, 0, 1, 32'h4);
        vecs[16] = mk(add123, 32'h104, 0, {5'd3, 5'd3, 5'd3}, 3'b110, 3'b111,
                      {32'hCD, 32'hAB, 32'hEE}, 0, 1, 0, 32'h22, 32'hAB, 32'hAB, 0, 0, 0);
        vecs[17] = mk(add123, 32'h104, 0, {5'd0, 5'd2, 5'd2}, 3'b011, 3'b001,
                      {32'd0, 32'h77, 32'd5}, 1, 1, add123, 32'd5, 32'd7, 32'd7, 0, 0, 0);
        vecs[18] = mk(beq_m2, 32'h100, 1, '0, '0, '0, '0,
                      0, 1, 0, 32'h100, 32'd0, 32'd0, 1, 0, 0);
        vecs[19] = mk(32'h0, 32'h40, 0, {5'd0, 5'd0, 5'd0}, 3'b001, 3'b000, '0,
                      1, 0, T_NOP, 0, 0, 0, 1, 0, 0);

        // Reset block.
        bus.inst_in = T_NOP;
        bus.pc_plus_four_in = '0;
        bus.stall_in = 1'b0;
        bus.irq_in = 1'b0;
        bus.rf_we = 1'b0;
        bus.rf_wa = '0;
        bus.rf_wd = '0;
        clear_byp();
        rst_n = 1'b0;
        step();
        step();
        settle();
        check("reset inst_next", bus.inst_next, T_NOP);
        check("reset pc_next", bus.pc_next, 32'h4);
        check("reset redirect_valid", 32'(bus.redirect_valid), 32'd0);
        check("reset stall_out", 32'(bus.stall_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Register file preload.
        rf_write(5'd0, 32'h1000);
        rf_write(5'd1, 32'h11);
        rf_write(5'd2, 32'h22);
        rf_write(5'd3, 32'd7);
        rf_write(5'd4, 32'h44);
        rf_write(5'd5, 32'h0);
        rf_write(5'd6, 32'h66);
        rf_write(5'd7, 32'h1003);

        for (int k = 0; k < 20; k++) run_vec(k);

        // Load-use: one bubble, then the value arrives from the mem stage.
        load_ir(sub546, 32'h104);
        bus.byp_rc = {5'd0, 5'd0, 5'd4};
        bus.byp_we = 3'b001;
        bus.byp_ready = 3'b000;
        settle();
        check("ldu stall_out", 32'(bus.stall_out), 32'd1);
        check("ldu bubble", bus.inst_next, T_NOP);
        bus.inst_in = add123;
        bus.pc_plus_four_in = 32'h108;
        step();
        bus.byp_rc = {5'd0, 5'd4, 5'd0};
        bus.byp_we = 3'b010;
        bus.byp_ready = 3'b010;
        bus.byp_data = {32'd0, 32'h99, 32'd0};
        settle();
        check("ldu release stall", 32'(bus.stall_out), 32'd0);
        check("ldu held inst", bus.inst_next, sub546);
        check("ldu a_data mem", bus.a_data, 32'h99);
        check("ldu b_data", bus.b_data, 32'h66);
        clear_byp();
        step();
        settle();
        check("ldu advance inst", bus.inst_next, add123);
        check("ldu advance pc", bus.pc_next, 32'h108);

        // Taken branch: the instruction loaded one edge later is annulled.
        load_ir(beq_m2, 32'h100);
        settle();
        check("br redirect_valid", 32'(bus.redirect_valid), 32'd1);
        check("br redirect_pc", bus.redirect_pc, 32'hF8);
        bus.inst_in = add123;
        bus.pc_plus_four_in = 32'h104;
        step();
        settle();
        check("br next pc", bus.pc_next, 32'h104);
        check("br one-shot rv", 32'(bus.redirect_valid), 32'd0);
        bus.inst_in = sub546;
        bus.pc_plus_four_in = 32'hFC;
        step();
        settle();
        check("br annulled", bus.inst_next, T_NOP);
        check("br annul pc", bus.pc_next, 32'hFC);
        bus.pc_plus_four_in = 32'h100;
        step();
        settle();
        check("br annul once", bus.inst_next, sub546);

        // Redirect suppressed during a downstream stall, re-asserted after.
        load_ir(beq_m2, 32'h100);
        bus.stall_in = 1'b1;
        settle();
        check("stl rv held", 32'(bus.redirect_valid), 32'd0);
        step();
        settle();
        check("stl rv still held", 32'(bus.redirect_valid), 32'd0);
        bus.stall_in = 1'b0;
        settle();
        check("stl rv reassert", 32'(bus.redirect_valid), 32'd1);
        check("stl redirect_pc", bus.redirect_pc, 32'hF8);
        check("stl pc held", bus.pc_next, 32'h100);

        // Writeback in the same cycle is visible to the reader.
        load_ir(add123, 32'h104);
        bus.rf_we = 1'b1;
        bus.rf_wa = 5'd2;
        bus.rf_wd = 32'h777;
        settle();
        check("wt same cycle", bus.a_data, 32'h777);
        step();
        bus.rf_we = 1'b0;
        settle();
        check("wt stored", bus.a_data, 32'h777);

`ifdef DECODE_IRQ_EN
        // Interrupt during an ADD held by a downstream stall.
        load_ir(add123, 32'h80);
        bus.stall_in = 1'b1;
        bus.irq_in = 1'b1;
        step();
        bus.irq_in = 1'b0;
        settle();
        check("irq no inject stalled", 32'(bus.redirect_valid), 32'd0);
        bus.stall_in = 1'b0;
        settle();
        check("irq inst_next", bus.inst_next, T_BNE_XP);
        check("irq a_data", bus.a_data, 32'h80);
        check("irq redirect_valid", 32'(bus.redirect_valid), 32'd1);
        check("irq redirect_pc", bus.redirect_pc, 32'h8);
        bus.inst_in = sub546;
        bus.pc_plus_four_in = 32'h84;
        step();
        settle();
        check("irq cleared", 32'(bus.redirect_valid), 32'd0);
        check("irq next inst", bus.inst_next, sub546);
        // Interrupt arriving during a load-use stall waits for it to clear.
        load_ir(add123, 32'h90);
        bus.byp_rc = {5'd0, 5'd0, 5'd2};
        bus.byp_we = 3'b001;
        bus.byp_ready = 3'b000;
        bus.irq_in = 1'b1;
        step();
        bus.irq_in = 1'b0;
        settle();
        check("irqhz stall", 32'(bus.stall_out), 32'd1);
        check("irqhz bubble", bus.inst_next, T_NOP);
        check("irqhz no rv", 32'(bus.redirect_valid), 32'd0);
        clear_byp();
        settle();
        check("irqhz inject", bus.inst_next, T_BNE_XP);
        check("irqhz rpc", bus.redirect_pc, 32'h8);
        check("irqhz a_data", bus.a_data, 32'h90);
`else
        // Without interrupt support irq_in has no effect.
        load_ir(add123, 32'h80);
        bus.stall_in = 1'b1;
        bus.irq_in = 1'b1;
        step();
        bus.irq_in = 1'b0;
        bus.stall_in = 1'b0;
        settle();
        check("noirq rv", 32'(bus.redirect_valid), 32'd0);
        check("noirq inst", bus.inst_next, add123);
`endif

        // Asynchronous reset mid-run with a redirect in decode.
        load_ir(beq_m2, 32'h100);
        settle();
        rst_n = 1'b0;
        #1;
        check("mid rst inst_next", bus.inst_next, T_NOP);
        check("mid rst pc_next", bus.pc_next, 32'h4);
        check("mid rst redirect", 32'(bus.redirect_valid), 32'd0);
        check("mid rst stall", 32'(bus.stall_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post rst inst", bus.inst_next, T_NOP);
        check("post rst pc", bus.pc_next, 32'h4);
        bus.inst_in = add123;
        bus.pc_plus_four_in = 32'h20;
        step();
        settle();
        check("post rst no annul", bus.inst_next, add123);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
